// File: rtl/aes_dec_pkg.sv
// Shared constants and state encoding for the AES-128 CBC decryptor sequencer.
package aes_dec_pkg;

   localparam int AES_BLK_W    = 128;
   localparam int AES_KEY_W    = 128;
   localparam int DEFAULT_WDOG = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      OUT   = 3'd4
   } state_t;

endpackage

// File: rtl/aes_dec_wdog.sv
// Watchdog counter: cleared on load, counts while enabled, flags the last
// allowed cycle so the caller can act on the same edge.
module aes_dec_wdog
   import aes_dec_pkg::*;
#(
   parameter int MAX = DEFAULT_WDOG
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic term
);

   localparam int W = $clog2(MAX + 1);

   logic [W-1:0] cnt;

   // Count enabled cycles; a clear always wins so each wait starts from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Terminal while in the MAX-th enabled cycle since the last clear.
   assign term = en && (cnt == W'(MAX - 1));

endmodule

// File: rtl/aes_dec_seq.sv
// Block sequencer for the iterative AES-128 CBC decryptor core: accepts one
// ciphertext block, drives it into the core, and returns the plaintext.
// The ciphertext stays on core_datain until the core's output strobe because
// the core takes it as the next chaining value at that point.
module aes_dec_seq
   import aes_dec_pkg::*;
#(
   parameter int WDOG_MAX = DEFAULT_WDOG,
   parameter int CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [AES_KEY_W-1:0] cfg_key,
   input  logic                 cfg_key_load,
   input  logic [AES_BLK_W-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic                 s_first,
   input  logic                 s_last,
   output logic [AES_BLK_W-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic                 core_rst,
   output logic [AES_BLK_W-1:0] core_datain,
   output logic                 core_dat_stb,
   output logic [AES_KEY_W-1:0] core_key,
   output logic                 core_key_valid,
   output logic                 core_o_stb,
   input  logic [AES_BLK_W-1:0] core_dataout,
   input  logic                 core_o_valid,
   input  logic                 core_ready,
   output logic                 busy,
   output logic [CNT_W-1:0]     blk_cnt,
   output logic                 err_timeout
);

   state_t               state, state_nxt;
   logic [AES_KEY_W-1:0] key_reg;
   logic                 key_loaded;
   logic [AES_BLK_W-1:0] cbuf;
   logic [AES_BLK_W-1:0] obuf;
   logic                 last_q;
   logic                 rst_hold;
   logic                 accept;
   logic                 timeout;
   logic                 wdog_clr;
   logic                 wdog_en;
   logic                 wdog_term;

   aes_dec_wdog #(
      .MAX (WDOG_MAX)
   ) u_wdog (
      .clk   (clk),
      .reset (reset),
      .clr   (wdog_clr),
      .en    (wdog_en),
      .term  (wdog_term)
   );

   // Next-state and per-state strobes; the key load takes priority over an input block.
   always_comb begin
      state_nxt      = state;
      s_ready        = 1'b0;
      core_dat_stb   = 1'b0;
      core_key_valid = 1'b0;
      core_o_stb     = 1'b0;
      m_valid        = 1'b0;
      accept         = 1'b0;
      timeout        = 1'b0;
      wdog_clr       = 1'b0;
      wdog_en        = 1'b0;
      case (state)
         IDLE: begin
            s_ready = key_loaded && !cfg_key_load;
            accept  = s_valid && key_loaded && !cfg_key_load;
            if (accept) begin
               state_nxt = s_first ? INIT : ISSUE;
            end
         end
         INIT: begin
            state_nxt = ISSUE;
         end
         ISSUE: begin
            core_dat_stb   = 1'b1;
            core_key_valid = 1'b1;
            if (core_ready) begin
               wdog_clr  = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            wdog_en = 1'b1;
            if (core_o_valid) begin
               core_o_stb = 1'b1;
               state_nxt  = OUT;
            end else if (wdog_term) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
         end
         OUT: begin
            m_valid = 1'b1;
            if (m_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Key register, writable only while idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_reg    <= '0;
         key_loaded <= 1'b0;
      end else if (state == IDLE && cfg_key_load) begin
         key_reg    <= cfg_key;
         key_loaded <= 1'b1;
      end
   end

   // Block buffers: ciphertext held from accept onward, plaintext taken at the core strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cbuf   <= '0;
         obuf   <= '0;
         last_q <= 1'b0;
      end else begin
         if (accept) begin
            cbuf   <= s_data;
            last_q <= s_last;
         end
         if (core_o_stb) begin
            obuf <= core_dataout;
         end
      end
   end

   // Core reset holder: set out of reset and for one cycle after a watchdog expiry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_hold <= 1'b1;
      end else begin
         rst_hold <= timeout;
      end
   end

   // Delivered-block counter and sticky timeout flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blk_cnt     <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (state == OUT && m_ready) begin
            blk_cnt <= blk_cnt + 1'b1;
         end
         if (timeout) begin
            err_timeout <= 1'b1;
         end
      end
   end

   assign core_rst    = rst_hold || (state == INIT);
   assign core_datain = cbuf;
   assign core_key    = key_reg;
   assign m_data      = obuf;
   assign m_last      = (state == OUT) && last_q;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_aes_dec_seq.sv
// Bench for aes_dec_seq with a behavioural CBC decryptor core model.
module tb_aes_dec_seq;

   localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] IV   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] XBLK = 128'h0123456789abcdeffedcba9876543210;
   localparam int           LAT  = 9;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [127:0] cfg_key = '0;
   logic         cfg_key_load = 1'b0;
   logic [127:0] s_data = '0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic         s_first = 1'b0;
   logic         s_last = 1'b0;
   logic [127:0] m_data;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic         m_last;
   logic         core_rst;
   logic [127:0] core_datain;
   logic         core_dat_stb;
   logic [127:0] core_key;
   logic         core_key_valid;
   logic         core_o_stb;
   logic [127:0] core_dataout;
   logic         core_o_valid = 1'b0;
   logic         core_ready;
   logic         busy;
   logic [15:0]  blk_cnt;
   logic         err_timeout;

   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   aes_dec_seq #(.WDOG_MAX(16), .CNT_W(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_key        (cfg_key),
      .cfg_key_load   (cfg_key_load),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_first        (s_first),
      .s_last         (s_last),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_last         (m_last),
      .core_rst       (core_rst),
      .core_datain    (core_datain),
      .core_dat_stb   (core_dat_stb),
      .core_key       (core_key),
      .core_key_valid (core_key_valid),
      .core_o_stb     (core_o_stb),
      .core_dataout   (core_dataout),
      .core_o_valid   (core_o_valid),
      .core_ready     (core_ready),
      .busy           (busy),
      .blk_cnt        (blk_cnt),
      .err_timeout    (err_timeout)
   );

   // Core model: known-answer for the FIPS-197 block under the right key,
   // an invertible stand-in otherwise; CBC chaining on o_stb, IV on reset.
   function automatic logic [127:0] dec_model(input logic [127:0] x, input logic [127:0] k);
      if (x == CT1 && k == KEY) return PT1;
      return ~x ^ k;
   endfunction

   logic [127:0] chain = '0;
   logic [127:0] cap = '0;
   logic         m_busy = 1'b0;
   int           lat_cnt = 0;
   bit           never_valid = 1'b0;

   assign core_ready   = !m_busy;
   assign core_dataout = cap ^ chain;

   always @(posedge clk) begin
      if (core_rst) begin
         chain        <= IV;
         m_busy       <= 1'b0;
         core_o_valid <= 1'b0;
      end else begin
         if (!m_busy && core_dat_stb && core_key_valid) begin
            m_busy  <= 1'b1;
            cap     <= dec_model(core_datain, core_key);
            lat_cnt <= LAT;
         end else if (m_busy && !core_o_valid) begin
            if (lat_cnt > 1) lat_cnt <= lat_cnt - 1;
            else if (!never_valid) core_o_valid <= 1'b1;
         end
         if (core_o_stb) begin
            chain        <= core_datain;
            core_o_valid <= 1'b0;
            m_busy       <= 1'b0;
         end
      end
   end

   // Event counters observed by the checks.
   int           rst_cycles = 0;
   int           ostb_cnt = 0;
   int           dstb_cnt = 0;
   logic [127:0] ostb_datain = '0;

   always @(posedge clk) begin
      if (core_rst) rst_cycles <= rst_cycles + 1;
      if (core_dat_stb) dstb_cnt <= dstb_cnt + 1;
      if (core_o_stb) begin
         ostb_cnt    <= ostb_cnt + 1;
         ostb_datain <= core_datain;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic load_key(input logic [127:0] k);
      cfg_key      = k;
      cfg_key_load = 1'b1;
      tick();
      cfg_key_load = 1'b0;
   endtask

   task automatic send(input string nm, input logic f, input logic l, input logic [127:0] d);
      int n;
      s_data  = d;
      s_first = f;
      s_last  = l;
      s_valid = 1'b1;
      #1;
      n = 0;
      while (s_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk({nm, "_accept"}, 128'(s_ready), 128'(1'b1));
      if (s_ready === 1'b1) tick();
      s_valid = 1'b0;
   endtask

   task automatic recv(input string nm, input logic [127:0] exp, input logic exp_last);
      int n;
      m_ready = 1'b1;
      n = 0;
      while (m_valid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk({nm, "_mvalid"}, 128'(m_valid), 128'(1'b1));
      if (m_valid === 1'b1) begin
         chk({nm, "_mdata"}, m_data, exp);
         chk({nm, "_mlast"}, 128'(m_last), 128'(exp_last));
         tick();
      end
      m_ready = 1'b0;
   endtask

   task automatic wait_issue(input string nm);
      int n;
      n = 0;
      while (core_dat_stb !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk({nm, "_issue"}, 128'(core_dat_stb), 128'(1'b1));
   endtask

   typedef struct {
      logic         first;
      logic         last;
      logic [127:0] data;
      logic [127:0] exp;
      logic         exp_last;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int           base_cnt, base_rst, base_ostb, base_dstb, n, n_first;
      logic [127:0] snap;
      bit           stable;

      vecs[0] = '{1'b1, 1'b1, CT1,  128'h00102030405060708090a0b0c0d0e0f0, 1'b1};
      vecs[1] = '{1'b1, 1'b0, CT1,  128'h00102030405060708090a0b0c0d0e0f0, 1'b0};
      vecs[2] = '{1'b0, 1'b1, CT1,  128'h69d5c2eb2e2e624750541d3bbc692ba5, 1'b1};
      vecs[3] = '{1'b0, 1'b0, XBLK, ~XBLK ^ KEY ^ CT1, 1'b0};
      vecs[4] = '{1'b1, 1'b1, XBLK, ~XBLK ^ KEY ^ IV, 1'b1};

      // Reset values
      tick();
      tick();
      chk("rst_ctrl",
          128'({s_ready, m_valid, m_last, core_dat_stb, core_key_valid, core_o_stb, busy, err_timeout, core_rst}),
          128'(9'b000000001));
      chk("rst_blk_cnt", 128'(blk_cnt), 128'(0));
      chk("rst_data", m_data | core_datain | core_key, 128'(0));
      #3 reset = 1'b1;
      #1 chk("rst_release_core_rst", 128'(core_rst), 128'(1'b1));
      tick();
      chk("core_rst_after_edge", 128'(core_rst), 128'(1'b0));

      // Key gating
      s_data  = CT1;
      s_first = 1'b1;
      s_last  = 1'b1;
      s_valid = 1'b1;
      tick();
      tick();
      tick();
      chk("nokey_sready", 128'({s_ready, busy}), 128'(2'b00));
      cfg_key      = KEY;
      cfg_key_load = 1'b1;
      #1 chk("keyload_sready", 128'(s_ready), 128'(1'b0));
      tick();
      cfg_key_load = 1'b0;
      #1 chk("after_load_sready", 128'({s_ready, busy}), 128'(2'b10));
      tick();
      s_valid = 1'b0;
      chk("accepted_busy", 128'(busy), 128'(1'b1));
      wait_issue("kg");
      tick();
      cfg_key      = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
      cfg_key_load = 1'b1;
      tick();
      cfg_key_load = 1'b0;
      chk("wait_load_ignored", core_key, KEY);
      recv("kg", 128'h00102030405060708090a0b0c0d0e0f0, 1'b1);
      chk("kg_blk_cnt", 128'(blk_cnt), 128'(1));
      chk("kg_ostb_datain", ostb_datain, CT1);

      // Vector table: FIPS-197 block and CBC chaining
      base_rst  = rst_cycles;
      base_ostb = ostb_cnt;
      base_cnt  = int'(blk_cnt);
      n_first   = 0;
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].first) n_first++;
         send($sformatf("vec%0d", i), vecs[i].first, vecs[i].last, vecs[i].data);
         recv($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp_last);
         chk($sformatf("vec%0d_ostb_datain", i), ostb_datain, vecs[i].data);
         chk($sformatf("vec%0d_blk_cnt", i), 128'(blk_cnt), 128'(base_cnt + i + 1));
      end
      chk("tbl_core_rst_cycles", 128'(rst_cycles - base_rst), 128'(n_first));
      chk("tbl_ostb_pulses", 128'(ostb_cnt - base_ostb), 128'(5));

      // Backpressure in OUT
      send("bp", 1'b1, 1'b1, CT1);
      n = 0;
      while (m_valid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("bp_reach_out", 128'(m_valid), 128'(1'b1));
      snap      = m_data;
      base_ostb = ostb_cnt;
      base_dstb = dstb_cnt;
      stable    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m_valid !== 1'b1 || m_data !== snap || s_ready !== 1'b0) stable = 1'b0;
      end
      chk("bp_stable", 128'(stable), 128'(1'b1));
      chk("bp_no_strobes", 128'((ostb_cnt - base_ostb) + (dstb_cnt - base_dstb)), 128'(0));
      base_cnt = int'(blk_cnt);
      recv("bp", 128'h00102030405060708090a0b0c0d0e0f0, 1'b1);
      chk("bp_one_transfer", 128'({m_valid, blk_cnt}), 128'({1'b0, 16'(base_cnt + 1)}));

      // Watchdog timeout
      never_valid = 1'b1;
      base_cnt    = int'(blk_cnt);
      send("to", 1'b1, 1'b1, CT1);
      wait_issue("to");
      n = 0;
      while (err_timeout !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("to_cycles", 128'(n), 128'(17));
      chk("to_idle_core_rst", 128'({err_timeout, busy, core_rst}), 128'(3'b101));
      tick();
      chk("to_core_rst_one_cycle", 128'(core_rst), 128'(1'b0));
      chk("to_blk_cnt", 128'(blk_cnt), 128'(base_cnt));
      never_valid = 1'b0;
      send("after_to", 1'b1, 1'b1, CT1);
      recv("after_to", 128'h00102030405060708090a0b0c0d0e0f0, 1'b1);
      chk("to_sticky", 128'({err_timeout, blk_cnt}), 128'({1'b1, 16'(base_cnt + 1)}));

      // Asynchronous reset during WAIT
      send("ar", 1'b1, 1'b1, CT1);
      wait_issue("ar");
      tick();
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      chk("ar_ctrl",
          128'({s_ready, m_valid, m_last, core_dat_stb, core_key_valid, core_o_stb, busy, err_timeout, core_rst}),
          128'(9'b000000001));
      chk("ar_vals", m_data | core_datain | core_key | 128'(blk_cnt), 128'(0));
      tick();
      tick();
      #3 reset = 1'b1;
      #1 chk("ar_release_core_rst", 128'(core_rst), 128'(1'b1));
      tick();
      chk("ar_core_rst_after_edge", 128'(core_rst), 128'(1'b0));
      load_key(KEY);
      send("ar_dec", 1'b1, 1'b1, CT1);
      recv("ar_dec", 128'h00102030405060708090a0b0c0d0e0f0, 1'b1);
      chk("ar_blk_cnt", 128'(blk_cnt), 128'(1));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/aes_dec_seq.md
Name: aes_dec_seq

Overview:
- Sequencer that feeds a ciphertext stream into the iterative AES-128 CBC decryptor core, one block at a time, and returns the plaintext stream.
- Owns the key register and keeps the core's datain stable until the output strobe, so the core's internal chaining value is correct.
- Re-initialises the core (restoring the IV) at each message start.
- Sits between the stream interconnect and the decryptor core; no pipelining.

Parameters:
- WDOG_MAX, 16: cycles allowed in WAIT before timeout (core nominal latency is 9).
- CNT_W, 16: width of the block counter.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_key  in  128  AES-128 key.
- cfg_key_load  in  1  load cfg_key; honoured in IDLE only.
- s_data  in  128  ciphertext block.
- s_valid  in  1  input valid.
- s_ready  out  1  input accept.
- s_first  in  1  first block of a message.
- s_last  in  1  last block of a message.
- m_data  out  128  plaintext block.
- m_valid  out  1  output valid.
- m_ready  in  1  output accept.
- m_last  out  1  copy of s_last for this block.
- core_rst  out  1  synchronous active-high reset to core.
- core_datain  out  128  core datain.
- core_dat_stb  out  1  core dat_stb.
- core_key  out  128  core key.
- core_key_valid  out  1  core key_valid.
- core_o_stb  out  1  core o_stb.
- core_dataout  in  128  core dataout.
- core_o_valid  in  1  core o_valid.
- core_ready  in  1  core ready.
- busy  out  1  state != IDLE.
- blk_cnt  out  CNT_W  blocks delivered; wraps.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (reset low, async):
  - State IDLE; key_loaded=0; blk_cnt=0; err_timeout=0.
  - s_ready, m_valid, m_last, core_dat_stb, core_key_valid, core_o_stb = 0.
  - m_data, core_datain, core_key = 0.
  - core_rst=1, so the core is held in reset; core_rst deasserts on the first clk edge after reset release.
  - Reset mid-operation discards any in-flight block.
- Key:
  - In IDLE, cfg_key_load=1 loads key_reg and sets key_loaded.
  - cfg_key_load outside IDLE is ignored.
  - core_key=key_reg at all times.
- States IDLE, INIT, ISSUE, WAIT, OUT:
  - IDLE:
    - s_ready=key_loaded && !cfg_key_load. If cfg_key_load and s_valid coincide, the key wins and the block waits.
    - On s_valid && s_ready: capture s_data into cbuf, capture s_last, and go to INIT if s_first, else ISSUE.
  - INIT: core_rst=1 for exactly one cycle -> ISSUE.
  - ISSUE:
    - core_dat_stb=1, core_key_valid=1.
    - On core_ready=1 -> WAIT, clear the watchdog; the strobes drop next cycle.
  - WAIT:
    - Watchdog increments each cycle.
    - On core_o_valid=1: capture core_dataout into obuf, pulse core_o_stb=1 for that cycle -> OUT.
    - If the watchdog reaches WDOG_MAX first: set err_timeout, pulse core_rst for one cycle, drop the block -> IDLE. The next message must start with s_first.
  - OUT:
    - m_valid=1, m_data=obuf, m_last=captured s_last.
    - On m_ready: blk_cnt+1 (wraps at 2^CNT_W) -> IDLE.
    - m_data/m_valid hold stable while m_ready=0.
- core_datain=cbuf from capture through the core_o_stb cycle. The core latches datain as the next chaining value at o_stb, so cbuf must not change before then.
- core_o_stb is asserted only in WAIT on core_o_valid; it is never asserted otherwise.
- Latency: 2 cycles (no s_first) or 3 cycles (s_first) from input accept to core accept; output is valid 1 cycle after core_o_valid.
- err_timeout clears only on reset.
- core_ready=0 in ISSUE stalls indefinitely; the watchdog does not run in ISSUE.

Decomposition:
- Package aes_dec_pkg holds:
  - AES_BLK_W=128 and AES_KEY_W=128.
  - The state enum (IDLE, INIT, ISSUE, WAIT, OUT).
  - DEFAULT_WDOG=16.
- Optional sub-module aes_dec_wdog: loadable counter with a terminal flag. Everything else stays in aes_dec_seq.

Test Plan:
1. FIPS-197 vector:
   - Stimulus: load key 000102030405060708090a0b0c0d0e0f; send s_first=1, s_last=1 block 69c4e0d86a7b0430d8cdb78070b4c55a.
   - Expect m_data=00102030405060708090a0b0c0d0e0f0 (plaintext XOR IV 000102..0f), m_last=1, blk_cnt=1.
   - Expect exactly one core_o_stb pulse with core_datain=69c4e0d8...c55a.
2. Chaining:
   - Stimulus: same key; send 69c4...c55a (first) then the same block again (not first).
   - Expect second m_data = 00112233445566778899aabbccddeeff ^ 69c4e0d86a7b0430d8cdb78070b4c55a.
   - Expect core_rst pulsed only once.
3. Backpressure:
   - Stimulus: hold m_ready=0 for 20 cycles in OUT.
   - Expect m_data/m_valid stable, s_ready=0, no core strobes; release gives one transfer.
4. Key gating:
   - Stimulus: s_valid with no key loaded; then cfg_key_load in the same cycle as s_valid; then cfg_key_load during WAIT.
   - Expect s_ready=0 until the key is loaded; the block is accepted the cycle after the load; the load during WAIT does not change core_key.
5. Timeout:
   - Stimulus: core model never raises o_valid.
   - Expect err_timeout=1 and a one-cycle core_rst after exactly 16 WAIT cycles, then IDLE, and blk_cnt unchanged.
6. Async reset:
   - Stimulus: assert reset during WAIT.
   - Expect outputs immediately at reset values, core_rst=1 until the first edge after release, and a clean decode of scenario 1 afterwards.
